// File: rtl/rfile_sb_pkg.sv
// Shared definitions for the rfile_sb register file and its scoreboard.
// Supplies the default data/address widths and the register count derived
// from the address width.
package rfile_sb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_W  = 3;

    // Number of architectural registers addressed by a reg_w-bit index.
    function automatic int nreg_of(input int reg_w);
        return 1 << reg_w;
    endfunction

endpackage

// File: rtl/rfile_sb_score.sv
// Pending-write scoreboard: per-register busy bits, issue acceptance, pend_cnt.
// Latency: a_rdy/b_rdy/issue_ack combinational; busy and pend_cnt update on the next edge.
// Backpressure: a refused issue (target busy, not retiring) changes nothing; decode holds and retries.
//
// Ports: clk/rst (async active-high), aadr/badr read addresses -> a_rdy/b_rdy,
//        we/cadr writeback retire, issue/iadr reservation -> issue_ack,
//        pend_cnt number of busy registers.
// Optional build macro RFILE_ZERO_REG_EN: register 0 is never reserved and always ready.
module rfile_sb_score
    import rfile_sb_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] aadr,
    input  logic [REG_W-1:0] badr,
    input  logic             we,
    input  logic [REG_W-1:0] cadr,
    input  logic             issue,
    input  logic [REG_W-1:0] iadr,
    output logic             a_rdy,
    output logic             b_rdy,
    output logic             issue_ack,
    output logic [REG_W:0]   pend_cnt
);

    localparam int NREG = nreg_of(REG_W);

`ifdef RFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic [NREG-1:0] r_busy;
    logic [REG_W:0]  r_cnt;
    logic [NREG-1:0] w_busy_nxt;
    logic [REG_W:0]  w_cnt_nxt;
    logic            w_a_retire;
    logic            w_b_retire;
    logic            w_i_retire;

    // A writeback landing this cycle makes the operand (or destination) free now.
    assign w_a_retire = we && (cadr == aadr);
    assign w_b_retire = we && (cadr == badr);
    assign w_i_retire = we && (cadr == iadr);

    assign a_rdy = !r_busy[aadr] || w_a_retire || (ZERO_EN && (aadr == '0));
    assign b_rdy = !r_busy[badr] || w_b_retire || (ZERO_EN && (badr == '0));
    assign issue_ack = issue && (!r_busy[iadr] || w_i_retire);

    // Retire first, then reserve, so a same-cycle reservation on cadr wins.
    // The count is recomputed from the next busy vector, which keeps it equal
    // to popcount(busy) through every retire/issue combination.
    always_comb begin
        w_busy_nxt = r_busy;
        if (we) begin
            w_busy_nxt[cadr] = 1'b0;
        end
        if (issue_ack) begin
            w_busy_nxt[iadr] = 1'b1;
        end
        if (ZERO_EN) begin
            w_busy_nxt[0] = 1'b0;
        end
        w_cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{REG_W{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign pend_cnt = r_cnt;

endmodule

// File: rtl/rfile_sb.sv
// Two-read/one-write register file with write-to-read bypass and pending-write scoreboard.
// Latency: reads are combinational (zero cycles); writes land on the next rising edge.
// Backpressure: none on reads/writes; issue is refused (issue_ack=0) while the target is busy.
//
// Ports: clk/rst (async active-high); aadr/badr -> a/b data and a_rdy/b_rdy;
//        we/cadr/c writeback (also retires the reservation on cadr);
//        issue/iadr -> issue_ack destination reservation; pend_cnt busy-register count.
// Optional build macro RFILE_ZERO_REG_EN: register 0 reads as constant zero and ignores writes.
module rfile_sb
    import rfile_sb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  aadr,
    input  logic [REG_W-1:0]  badr,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              a_rdy,
    output logic              b_rdy,
    input  logic [REG_W-1:0]  cadr,
    input  logic [DATA_W-1:0] c,
    input  logic              we,
    input  logic              issue,
    input  logic [REG_W-1:0]  iadr,
    output logic              issue_ack,
    output logic [REG_W:0]    pend_cnt
);

    localparam int NREG = nreg_of(REG_W);

`ifdef RFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic [DATA_W-1:0] r_regs [NREG];
    logic              w_wr_en;
    logic              w_a_zero;
    logic              w_b_zero;

    assign w_wr_en  = we && !(ZERO_EN && (cadr == '0));
    assign w_a_zero = ZERO_EN && (aadr == '0);
    assign w_b_zero = ZERO_EN && (badr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[cadr] <= c;
        end
    end

    // Bypass forwards the in-flight write; the hard-wired zero register overrides it.
    assign a = w_a_zero ? '0 : ((we && (cadr == aadr)) ? c : r_regs[aadr]);
    assign b = w_b_zero ? '0 : ((we && (cadr == badr)) ? c : r_regs[badr]);

    rfile_sb_score #(
        .REG_W (REG_W)
    ) u_score (
        .clk       (clk),
        .rst       (rst),
        .aadr      (aadr),
        .badr      (badr),
        .we        (we),
        .cadr      (cadr),
        .issue     (issue),
        .iadr      (iadr),
        .a_rdy     (a_rdy),
        .b_rdy     (b_rdy),
        .issue_ack (issue_ack),
        .pend_cnt  (pend_cnt)
    );

endmodule

// File: tb/tb_rfile_sb.sv
// Testbench for rfile_sb: directed scenarios plus randomized traffic against a
// behavioural model (array of register values and busy flags).
module tb_rfile_sb;

`ifdef RFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  aadr, badr, cadr, iadr;
    logic [15:0] c;
    logic        we, issue;
    logic [15:0] a, b;
    logic        a_rdy, b_rdy, issue_ack;
    logic [3:0]  pend_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mr [8];
    bit          mb [8];

    always #5 clk = ~clk;

    rfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .aadr      (aadr),
        .badr      (badr),
        .a         (a),
        .b         (b),
        .a_rdy     (a_rdy),
        .b_rdy     (b_rdy),
        .cadr      (cadr),
        .c         (c),
        .we        (we),
        .issue     (issue),
        .iadr      (iadr),
        .issue_ack (issue_ack),
        .pend_cnt  (pend_cnt)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] m_rd(input logic [2:0] ad);
        if (ZR && ad == 3'd0) return 16'h0000;
        if (we && cadr == ad) return c;
        return mr[ad];
    endfunction

    function automatic logic m_rdy(input logic [2:0] ad);
        if (ZR && ad == 3'd0) return 1'b1;
        return !mb[ad] || (we && cadr == ad);
    endfunction

    function automatic logic m_ack();
        return issue && (!mb[iadr] || (we && cadr == iadr));
    endfunction

    function automatic logic [3:0] m_cnt();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(mb[i]);
        return 4'(n);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) begin
            mr[i] = 16'h0000;
            mb[i] = 1'b0;
        end
    endtask

    // Called at posedge+1; applies inputs and waits to the falling edge.
    task automatic drive(input logic [2:0] aa, input logic [2:0] ba, input logic w,
                         input logic [2:0] ca, input logic [15:0] cd,
                         input logic is, input logic [2:0] ia);
        aadr = aa; badr = ba; we = w; cadr = ca; c = cd; issue = is; iadr = ia;
        #4;
    endtask

    // Advance one clock edge and update the model with the inputs seen at that edge.
    task automatic tick();
        logic ack;
        ack = m_ack();
        @(posedge clk);
        if (we && !(ZR && cadr == 3'd0)) mr[cadr] = c;
        if (we) mb[cadr] = 1'b0;
        if (ack && !(ZR && iadr == 3'd0)) mb[iadr] = 1'b1;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        we = 0; issue = 0; cadr = 0; c = 0; iadr = 0;
        rst = 1'b1;
        #1;
        m_clear();
        for (int i = 0; i < 8; i++) begin
            aadr = 3'(i); badr = 3'(7 - i);
            #1;
            n_tests++; if (a !== 16'h0000) begin n_fail++; $display("FAIL reset_a[%0d]: got %h want 0000", i, a); end
            n_tests++; if (b !== 16'h0000) begin n_fail++; $display("FAIL reset_b[%0d]: got %h want 0000", i, b); end
            n_tests++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy[%0d]: got %b%b want 11", i, a_rdy, b_rdy); end
        end
        n_tests++; if (pend_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_pend: got %0d want 0", pend_cnt); end
        n_tests++; if (issue_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", issue_ack); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        drive(3'd3, 3'd3, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0);
        n_tests++; if (a !== 16'h1234) begin n_fail++; $display("FAIL bypass_a: got %h want 1234", a); end
        n_tests++; if (b !== 16'h1234) begin n_fail++; $display("FAIL bypass_b: got %h want 1234", b); end
        tick();
        drive(3'd3, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        n_tests++; if (a !== 16'h1234) begin n_fail++; $display("FAIL write_a: got %h want 1234", a); end
        n_tests++; if (b !== m_rd(3'd2)) begin n_fail++; $display("FAIL write_b_other: got %h want %h", b, m_rd(3'd2)); end
    endtask

    task automatic test_issue_retire();
        drive(3'd5, 3'd5, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5);
        n_tests++; if (issue_ack !== 1'b1) begin n_fail++; $display("FAIL issue_ack: got %b want 1", issue_ack); end
        tick();
        drive(3'd5, 3'd4, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        n_tests++; if (pend_cnt !== 4'd1) begin n_fail++; $display("FAIL issue_pend: got %0d want 1", pend_cnt); end
        n_tests++; if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL busy_rdy: got %b want 0", a_rdy); end
        n_tests++; if (b_rdy !== 1'b1) begin n_fail++; $display("FAIL other_rdy: got %b want 1", b_rdy); end
        drive(3'd5, 3'd5, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0);
        n_tests++; if (a_rdy !== 1'b1 || a !== 16'hBEEF) begin n_fail++; $display("FAIL retire_byp: got rdy=%b a=%h want 1 beef", a_rdy, a); end
        tick();
        drive(3'd5, 3'd5, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        n_tests++; if (pend_cnt !== 4'd0) begin n_fail++; $display("FAIL retire_pend: got %0d want 0", pend_cnt); end
        n_tests++; if (a !== 16'hBEEF || a_rdy !== 1'b1) begin n_fail++; $display("FAIL retire_a: got %h rdy=%b want beef 1", a, a_rdy); end
    endtask

    task automatic test_refuse();
        drive(3'd5, 3'd5, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5);
        tick();
        drive(3'd5, 3'd5, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5);
        n_tests++; if (issue_ack !== 1'b0) begin n_fail++; $display("FAIL refuse_ack: got %b want 0", issue_ack); end
        tick();
        drive(3'd5, 3'd5, 1'b1, 3'd5, 16'h5A5A, 1'b1, 3'd5);
        n_tests++; if (pend_cnt !== 4'd1) begin n_fail++; $display("FAIL refuse_pend: got %0d want 1", pend_cnt); end
        n_tests++; if (issue_ack !== 1'b1) begin n_fail++; $display("FAIL reissue_ack: got %b want 1", issue_ack); end
        tick();
        drive(3'd5, 3'd5, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        n_tests++; if (pend_cnt !== 4'd1) begin n_fail++; $display("FAIL reissue_pend: got %0d want 1", pend_cnt); end
        n_tests++; if (a_rdy !== 1'b0 || a !== 16'h5A5A) begin n_fail++; $display("FAIL reissue_state: got rdy=%b a=%h want 0 5a5a", a_rdy, a); end
        drive(3'd5, 3'd5, 1'b1, 3'd5, 16'h0F0F, 1'b0, 3'd0);
        tick();
    endtask

    task automatic test_fill_drain_reset();
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 3'(i), 1'b0, 3'd0, 16'h0000, 1'b1, 3'(i));
            n_tests++; if (issue_ack !== 1'b1) begin n_fail++; $display("FAIL fill_ack[%0d]: got %b want 1", i, issue_ack); end
            tick();
            drive(3'(i), 3'(i), 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
            n_tests++; if (pend_cnt !== m_cnt()) begin n_fail++; $display("FAIL fill_pend[%0d]: got %0d want %0d", i, pend_cnt, m_cnt()); end
        end
        n_tests++; if (pend_cnt !== (ZR ? 4'd7 : 4'd8)) begin n_fail++; $display("FAIL full_pend: got %0d want %0d", pend_cnt, ZR ? 7 : 8); end
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 3'(7 - i), 1'b1, 3'(i), 16'($urandom), 1'b0, 3'd0);
            tick();
            drive(3'(i), 3'(i), 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
            n_tests++; if (pend_cnt !== m_cnt()) begin n_fail++; $display("FAIL drain_pend[%0d]: got %0d want %0d", i, pend_cnt, m_cnt()); end
            n_tests++; if (a !== m_rd(3'(i))) begin n_fail++; $display("FAIL drain_a[%0d]: got %h want %h", i, a, m_rd(3'(i))); end
        end
        for (int i = 4; i < 8; i++) begin
            drive(3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'(i));
            tick();
        end
        drive(3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        n_tests++; if (pend_cnt !== 4'd4) begin n_fail++; $display("FAIL pre_rst_pend: got %0d want 4", pend_cnt); end
        rst = 1'b1;
        #1;
        m_clear();
        n_tests++; if (pend_cnt !== 4'd0) begin n_fail++; $display("FAIL midrst_pend: got %0d want 0", pend_cnt); end
        for (int i = 0; i < 8; i++) begin
            aadr = 3'(i); badr = 3'(i);
            #1;
            n_tests++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1 || a !== 16'h0000) begin n_fail++; $display("FAIL midrst_rd[%0d]: got rdy=%b%b a=%h want 11 0000", i, a_rdy, b_rdy, a); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            n_tests++; if (a !== m_rd(aadr)) begin n_fail++; $display("FAIL rnd_a[%0d]: got %h want %h", n, a, m_rd(aadr)); end
            n_tests++; if (b !== m_rd(badr)) begin n_fail++; $display("FAIL rnd_b[%0d]: got %h want %h", n, b, m_rd(badr)); end
            n_tests++; if (a_rdy !== m_rdy(aadr)) begin n_fail++; $display("FAIL rnd_a_rdy[%0d]: got %b want %b", n, a_rdy, m_rdy(aadr)); end
            n_tests++; if (b_rdy !== m_rdy(badr)) begin n_fail++; $display("FAIL rnd_b_rdy[%0d]: got %b want %b", n, b_rdy, m_rdy(badr)); end
            n_tests++; if (issue_ack !== m_ack()) begin n_fail++; $display("FAIL rnd_ack[%0d]: got %b want %b", n, issue_ack, m_ack()); end
            n_tests++; if (pend_cnt !== m_cnt()) begin n_fail++; $display("FAIL rnd_pend[%0d]: got %0d want %0d", n, pend_cnt, m_cnt()); end
            tick();
        end
    endtask

`ifdef RFILE_ZERO_REG_EN
    task automatic test_zero_reg();
        drive(3'd0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0);
        n_tests++; if (a !== 16'h0000) begin n_fail++; $display("FAIL zr_byp_a: got %h want 0000", a); end
        tick();
        drive(3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0);
        n_tests++; if (a !== 16'h0000) begin n_fail++; $display("FAIL zr_a: got %h want 0000", a); end
        n_tests++; if (issue_ack !== 1'b1) begin n_fail++; $display("FAIL zr_ack: got %b want 1", issue_ack); end
        tick();
        drive(3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
        n_tests++; if (pend_cnt !== 4'd0 || a_rdy !== 1'b1) begin n_fail++; $display("FAIL zr_pend: got %0d rdy=%b want 0 1", pend_cnt, a_rdy); end
    endtask
`endif

    initial begin
        rst = 1'b0; we = 0; issue = 0; aadr = 0; badr = 0; cadr = 0; iadr = 0; c = 0;
        m_clear();
        @(posedge clk); #1;
        test_reset();
        test_bypass();
        test_issue_retire();
        test_refuse();
        test_fill_drain_reset();
`ifdef RFILE_ZERO_REG_EN
        test_zero_reg();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
